seq_datapath: RTL and testbench

Parametrised successor to the Lab 7 16-bit datapath. It is a self-sequencing multicycle datapath: it accepts one micro-op per valid/ready handshake and walks it through register read, execute and writeback with its own state machine. It generalises data width, register count and immediate width, and adds a done handshake, shift modes and a short path for non-ALU writes. It sits between the instruction decoder/controller and memory.

---
 rtl/dp_pkg.sv | 41 ++++
 rtl/dp_regfile.sv | 36 +++
 rtl/seq_datapath.sv | 215 +++++++++++++++++++++
 tb/tb_seq_datapath.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// ============================================================================
// Module      : dp_pkg
// Description : Shared micro-op field encodings and FSM states for seq_datapath
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    WS_ALU   = 2'b00,
    WS_IMM   = 2'b01,
    WS_MDATA = 2'b10,
    WS_PC    = 2'b11
  } wsel_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dp_regfile.sv
// ============================================================================
// Module      : dp_regfile
// Description : NREGS x WIDTH register file, one sync write, one comb read
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic [RW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/seq_datapath.sv
// ============================================================================
// Module      : seq_datapath
// Description : Self-sequencing multicycle datapath (RD_A/RD_B/EXEC/WB).
//               Optional STATUS_CARRY_EN adds the Cf carry status output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_datapath
  import dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMMW  = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_alu,
  input  logic [1:0]       op_shift,
  input  logic [RW-1:0]    op_rn,
  input  logic [RW-1:0]    op_rm,
  input  logic [RW-1:0]    op_rd,
  input  logic             op_asel,
  input  logic             op_bsel,
  input  logic [IMMW-1:0]  op_imm,
  input  logic [1:0]       op_wsel,
  input  logic             op_write,
  input  logic             op_loads,
  input  logic [WIDTH-1:0] mdata,
  input  logic [WIDTH-1:0] pc,
  output logic             done,
  output logic [WIDTH-1:0] datapath_out,
`ifdef STATUS_CARRY_EN
  output logic             Cf,
`endif
  output logic             N,
  output logic             Z,
  output logic             V
);

  state_t           r_state, w_next;
  alu_op_t          r_alu;
  shift_t           r_shift;
  wsel_t            r_wsel;
  logic [RW-1:0]    r_rn, r_rm, r_rd;
  logic             r_asel, r_bsel, r_write, r_loads;
  logic [IMMW-1:0]  r_imm;
  logic [WIDTH-1:0] r_a, r_b, r_c;
  logic             r_n, r_z, r_v;

  logic             w_accept, w_we;
  logic [RW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_rdata, w_wdata, w_imm_ext, w_bsh, w_ain, w_bin, w_res;
  logic             w_v;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (op_valid) w_next = (wsel_t'(op_wsel) == WS_ALU) ? ST_RD_A : ST_WB;
      ST_RD_A: w_next = ST_RD_B;
      ST_RD_B: w_next = ST_EXEC;
      ST_EXEC: w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    op_ready = (r_state == ST_IDLE);
    done     = (r_state == ST_WB);
    w_we     = (r_state == ST_WB) && r_write;
    w_raddr  = (r_state == ST_RD_B) ? r_rm : r_rn;
  end

  assign w_accept = op_ready && op_valid;

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_waddr (r_rd),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_imm_ext = WIDTH'($signed(r_imm));

  always_comb begin
    case (r_shift)
      SH_LSL1: w_bsh = {r_b[WIDTH-2:0], 1'b0};
      SH_LSR1: w_bsh = {1'b0, r_b[WIDTH-1:1]};
      SH_ASR1: w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_bsh = r_b;
    endcase
  end

  assign w_ain = r_asel ? '0 : r_a;
  assign w_bin = r_bsel ? w_imm_ext : w_bsh;

  // Overflow: operands (B inverted for SUB) agree in sign but result differs
  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    case (r_alu)
      ALU_ADD: begin
        w_res = w_ain + w_bin;
        w_v   = ~(w_ain[WIDTH-1] ^ w_bin[WIDTH-1]) & (w_ain[WIDTH-1] ^ w_res[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_ain - w_bin;
        w_v   = (w_ain[WIDTH-1] ^ w_bin[WIDTH-1]) & (w_ain[WIDTH-1] ^ w_res[WIDTH-1]);
      end
      ALU_AND: w_res = w_ain & w_bin;
      default: w_res = ~w_bin;
    endcase
  end

  always_comb begin
    case (r_wsel)
      WS_IMM:   w_wdata = w_imm_ext;
      WS_MDATA: w_wdata = mdata;
      WS_PC:    w_wdata = pc;
      default:  w_wdata = r_c;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu   <= ALU_ADD;
      r_shift <= SH_NONE;
      r_wsel  <= WS_ALU;
      r_rn    <= '0;
      r_rm    <= '0;
      r_rd    <= '0;
      r_asel  <= 1'b0;
      r_bsel  <= 1'b0;
      r_write <= 1'b0;
      r_loads <= 1'b0;
      r_imm   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu   <= alu_op_t'(op_alu);
        r_shift <= shift_t'(op_shift);
        r_wsel  <= wsel_t'(op_wsel);
        r_rn    <= op_rn;
        r_rm    <= op_rm;
        r_rd    <= op_rd;
        r_asel  <= op_asel;
        r_bsel  <= op_bsel;
        r_write <= op_write;
        r_loads <= op_loads;
        r_imm   <= op_imm;
      end
      if (r_state == ST_RD_A) r_a <= w_rdata;
      if (r_state == ST_RD_B) r_b <= w_rdata;
      if (r_state == ST_EXEC) begin
        r_c <= w_res;
        if (r_loads) begin
          r_n <= w_res[WIDTH-1];
          r_z <= (w_res == '0);
          r_v <= w_v;
        end
      end
    end
  end

`ifdef STATUS_CARRY_EN
  logic             r_cf, w_cout;
  logic [WIDTH:0]   w_sum_ext;

  assign w_sum_ext = {1'b0, w_ain} + {1'b0, w_bin};

  // SUB reports NOT borrow, i.e. unsigned Ain >= Bin
  always_comb begin
    case (r_alu)
      ALU_ADD: w_cout = w_sum_ext[WIDTH];
      ALU_SUB: w_cout = (w_ain >= w_bin);
      default: w_cout = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            r_cf <= 1'b0;
    else if (r_state == ST_EXEC && r_loads)  r_cf <= w_cout;
  end

  assign Cf = r_cf;
`endif

  assign datapath_out = r_c;
  assign N = r_n;
  assign Z = r_z;
  assign V = r_v;

endmodule

`default_nettype wire

// File: tb/tb_seq_datapath.sv
// ============================================================================
// Module      : tb_seq_datapath
// Description : Directed + random self-checking bench for seq_datapath
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_datapath;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_alu, op_shift, op_wsel;
  logic [2:0]  op_rn, op_rm, op_rd;
  logic        op_asel, op_bsel, op_write, op_loads;
  logic [7:0]  op_imm;
  logic [15:0] mdata, pc;
  logic        done;
  logic [15:0] datapath_out;
  logic        N, Z, V;
`ifdef STATUS_CARRY_EN
  logic        Cf;
`endif

  int tests = 0;
  int fails = 0;

  // reference state
  longint m_r [8];
  longint m_c;
  logic   m_n, m_z, m_v, m_cf;

  always #5 clk = ~clk;

  seq_datapath dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_alu       (op_alu),
    .op_shift     (op_shift),
    .op_rn        (op_rn),
    .op_rm        (op_rm),
    .op_rd        (op_rd),
    .op_asel      (op_asel),
    .op_bsel      (op_bsel),
    .op_imm       (op_imm),
    .op_wsel      (op_wsel),
    .op_write     (op_write),
    .op_loads     (op_loads),
    .mdata        (mdata),
    .pc           (pc),
    .done         (done),
    .datapath_out (datapath_out),
`ifdef STATUS_CARRY_EN
    .Cf           (Cf),
`endif
    .N            (N),
    .Z            (Z),
    .V            (V)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] alu, input logic [1:0] sh,
                        input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                        input logic asel, input logic bsel, input logic [7:0] imm,
                        input logic [1:0] wsel, input logic wr, input logic ld,
                        input logic [15:0] md, input logic [15:0] p);
    op_alu = alu; op_shift = sh; op_rn = rn; op_rm = rm; op_rd = rd;
    op_asel = asel; op_bsel = bsel; op_imm = imm; op_wsel = wsel;
    op_write = wr; op_loads = ld; mdata = md; pc = p;
  endtask

  function automatic longint to_signed(input longint u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  function automatic longint sext_imm(input longint i);
    return (i >= 128) ? i + 65280 : i;
  endfunction

  // Applies the currently driven op to the reference state, arithmetically
  task automatic model_op();
    longint a, b, sa, sb, full, res, sf, wd;
    logic   v, cy;
    res = 0; v = 0; cy = 0;
    if (op_wsel == 2'b00) begin
      a = op_asel ? 0 : m_r[op_rn];
      b = m_r[op_rm];
      case (op_shift)
        2'b01: b = (b * 2) % 65536;
        2'b10: b = b / 2;
        2'b11: b = b / 2 + ((b >= 32768) ? 32768 : 0);
        default: ;
      endcase
      if (op_bsel) b = sext_imm(longint'(op_imm));
      sa = to_signed(a);
      sb = to_signed(b);
      case (op_alu)
        2'b00: begin
          full = a + b; res = full % 65536; cy = (full >= 65536);
          sf = sa + sb; v = (sf > 32767) || (sf < -32768);
        end
        2'b01: begin
          res = (a - b + 65536) % 65536; cy = (a >= b);
          sf = sa - sb; v = (sf > 32767) || (sf < -32768);
        end
        2'b10: res = longint'(16'(a) & 16'(b));
        default: res = 65535 - b;
      endcase
      m_c = res;
      if (op_loads) begin
        m_z = (res == 0); m_n = (res >= 32768); m_v = v; m_cf = cy;
      end
      wd = res;
    end else begin
      case (op_wsel)
        2'b01:   wd = sext_imm(longint'(op_imm));
        2'b10:   wd = longint'(mdata);
        default: wd = longint'(pc);
      endcase
    end
    if (op_write) m_r[op_rd] = wd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_c = 0; m_n = 0; m_z = 0; m_v = 0; m_cf = 0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_dout"}, 32'(datapath_out), 32'(m_c));
    chk({tag, "_nzv"}, {29'd0, N, Z, V}, {29'd0, m_n, m_z, m_v});
`ifdef STATUS_CARRY_EN
    chk({tag, "_cf"}, {31'd0, Cf}, {31'd0, m_cf});
`endif
  endtask

  // Issue one op (fields already driven), check latency, pulse width and result
  task automatic run_op(input string tag);
    int n;
    int exp_lat;
    @(negedge clk);
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_op();
    exp_lat = (op_wsel == 2'b00) ? 4 : 1;
    n = 1;
    while (done !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, (done === 1'b1) ? n : 0, exp_lat);
    @(posedge clk); #1;
    chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    check_status(tag);
  endtask

  task automatic read_reg(input string tag, input logic [2:0] r);
    set_op(2'b00, 2'b00, r, 3'd0, 3'd0, 1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    run_op(tag);
    chk({tag, "_val"}, 32'(datapath_out), 32'(m_r[r]));
  endtask

  initial begin
    int dones;
    model_reset();
    reset_n  = 1'b0;
    op_valid = 1'b0;
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    #12;
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_dout", 32'(datapath_out), 32'd0);
    chk("rst_nzv", {29'd0, N, Z, V}, 32'd0);
    for (int i = 0; i < 8; i++) read_reg("rst_reg", 3'(i));

    // MOV immediate, sign-extended
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'hF9, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0);
    run_op("mov_imm");
    read_reg("mov_r0", 3'd0);
    chk("mov_r0_fff9", 32'(datapath_out), 32'h0000_FFF9);

    // ADD with LSL1 on B: 7 + (3<<1) = 13
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 8'd7, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0);
    run_op("ld_r1");
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 8'd3, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0);
    run_op("ld_r2");
    set_op(2'b00, 2'b01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0);
    run_op("add_lsl");
    chk("add_lsl_13", 32'(datapath_out), 32'd13);
    read_reg("add_r3", 3'd3);

    // SUB overflow, then self-subtract to zero
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 8'h00, 2'b10, 1'b1, 1'b0, 16'h8000, 16'h0);
    run_op("ld_mdata");
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 8'd1, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0);
    run_op("ld_one");
    set_op(2'b01, 2'b00, 3'd1, 3'd2, 3'd4, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0);
    run_op("sub_ovf");
    chk("sub_ovf_nzv", {29'd0, N, Z, V}, 32'b001);
    chk("sub_ovf_val", 32'(datapath_out), 32'h7FFF);
    set_op(2'b01, 2'b00, 3'd1, 3'd1, 3'd5, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0);
    run_op("sub_zero");
    chk("sub_zero_nzv", {29'd0, N, Z, V}, 32'b010);

    // PC writeback
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd6, 1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 16'h0, 16'h1234);
    run_op("ld_pc");
    read_reg("pc_r6", 3'd6);

    // Busy hold: op_valid held across two back-to-back ALU ops
    dones = 0;
    set_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd4, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0);
    @(negedge clk);
    op_valid = 1'b1;
    @(posedge clk); #1;
    model_op();
    set_op(2'b01, 2'b00, 3'd4, 3'd2, 3'd5, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_ready_low", {31'd0, op_ready}, 32'd0);
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    chk("busy_ready_idle", {31'd0, op_ready}, 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("busy_accept2", {31'd0, op_ready}, 32'd0);
    model_op();
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    chk("busy_two_dones", dones, 2);
    check_status("busy_op2");
    read_reg("busy_r5", 3'd5);

    // Reset during EXEC aborts the op
    set_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0, 8'd5, 2'b01, 1'b1, 1'b0, 16'h0, 16'h0);
    run_op("ld_r3_5");
    set_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b1, 16'h0, 16'h0);
    @(negedge clk);
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("abort_ready", {31'd0, op_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    check_status("abort");
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    read_reg("abort_r3", 3'd3);

    // Randomised ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      set_op(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom),
             ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
             1'($urandom_range(0, 4) != 0), 1'($urandom),
             16'($urandom), 16'($urandom));
      run_op("rand");
    end
    for (int i = 0; i < 8; i++) read_reg("final_reg", 3'(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
